// File: rtl/lcd_pkg.sv
// lcd_pkg: shared timing defaults, FSM state type and sizing helpers for the LCD timing generator
package lcd_pkg;
  typedef enum logic {IDLE, RUN} lcd_state_e;
  localparam int DEF_DATA_W  = 16;
  localparam int DEF_H_SYNC  = 1;
  localparam int DEF_H_BACK  = 46;
  localparam int DEF_H_DISP  = 800;
  localparam int DEF_H_FRONT = 210;
  localparam int DEF_V_SYNC  = 1;
  localparam int DEF_V_BACK  = 23;
  localparam int DEF_V_DISP  = 480;
  localparam int DEF_V_FRONT = 22;
  localparam int PIPE_DEPTH  = 3;
  function automatic int total4(int a, int b, int c, int d);
    return a + b + c + d;
  endfunction
  function automatic int cnt_w(int total);
    return (total < 2) ? 1 : $clog2(total);
  endfunction
endpackage

// File: rtl/lcd_timing_gen_if.sv
// lcd_timing_gen_if: run request, FIFO read handshake and LCD pin bundle
// master: timing generator side; slave: FIFO read controller / panel / control side
interface lcd_timing_gen_if import lcd_pkg::*; #(parameter int DATA_W = DEF_DATA_W);
  logic              lcd_en;
  logic              lcd_data_requst;
  logic              fifo_rd_en;
  logic [DATA_W-1:0] fifo_rd_data;
  logic              lcd_hs;
  logic              lcd_vs;
  logic              lcd_de;
  logic [DATA_W-1:0] lcd_rgb;
  logic              frame_start;
  logic              lcd_underflow;
  logic [15:0]       underflow_cnt;
  modport master (
    input  lcd_en, fifo_rd_en, fifo_rd_data,
    output lcd_data_requst, lcd_hs, lcd_vs, lcd_de, lcd_rgb, frame_start, lcd_underflow, underflow_cnt
  );
  modport slave (
    output lcd_en, fifo_rd_en, fifo_rd_data,
    input  lcd_data_requst, lcd_hs, lcd_vs, lcd_de, lcd_rgb, frame_start, lcd_underflow, underflow_cnt
  );
endinterface

// File: rtl/lcd_delay_line.sv
// lcd_delay_line: DEPTH-stage shift register with synchronous active-low clear
// Ports: clk - clock; rst_n - sync active-low clear; i_d - input word; o_q - input delayed DEPTH clocks
module lcd_delay_line #(
  parameter int DEPTH = 3,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH-1:0] r_sr [DEPTH];
  always_ff @(posedge clk) begin
    if (!rst_n) r_sr <= '{default: '0};
    else begin
      r_sr[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
    end
  end
  assign o_q = r_sr[DEPTH-1];
endmodule

// File: rtl/lcd_timing_gen.sv
// lcd_timing_gen: LCD sync/DE timing with one-ahead FIFO request, pixel capture and underflow tracking
// Ports:
//   lcd_clk - pixel clock, shared with the FIFO read side
//   rst_n   - synchronous active-low reset
//   bus     - master view: lcd_en/fifo_rd_en/fifo_rd_data in; request, sync/DE/RGB pins, frame_start,
//             underflow pulse and saturating underflow count out
module lcd_timing_gen import lcd_pkg::*; #(
  parameter int   DATA_W  = DEF_DATA_W,
  parameter int   H_SYNC  = DEF_H_SYNC,
  parameter int   H_BACK  = DEF_H_BACK,
  parameter int   H_DISP  = DEF_H_DISP,
  parameter int   H_FRONT = DEF_H_FRONT,
  parameter int   V_SYNC  = DEF_V_SYNC,
  parameter int   V_BACK  = DEF_V_BACK,
  parameter int   V_DISP  = DEF_V_DISP,
  parameter int   V_FRONT = DEF_V_FRONT,
  parameter logic HS_POL  = 1'b0,
  parameter logic VS_POL  = 1'b0
) (
  input logic              lcd_clk,
  input logic              rst_n,
  lcd_timing_gen_if.master bus
);
  localparam int H_TOTAL = total4(H_SYNC, H_BACK, H_DISP, H_FRONT);
  localparam int V_TOTAL = total4(V_SYNC, V_BACK, V_DISP, V_FRONT);
  localparam int H_CW    = cnt_w(H_TOTAL);
  localparam int V_CW    = cnt_w(V_TOTAL);
  localparam int H_A0    = H_SYNC + H_BACK;
  localparam int H_A1    = H_A0 + H_DISP;
  localparam int V_A0    = V_SYNC + V_BACK;
  localparam int V_A1    = V_A0 + V_DISP;
  lcd_state_e        r_state, w_state_nxt;
  logic [H_CW-1:0]   r_h, w_h_nxt;
  logic [V_CW-1:0]   r_v, w_v_nxt;
  logic              w_h_end, w_v_end, w_run, w_hs, w_vs, w_act, w_fs, w_uf;
  logic              r_req, r_req_d1, r_rd_en_d1, r_uf;
  logic [DATA_W-1:0] r_rgb;
  logic [15:0]       r_uf_cnt;
  logic [3:0]        w_ctl;
  always_comb begin
    w_h_end     = r_h == H_CW'(H_TOTAL - 1);
    w_v_end     = r_v == V_CW'(V_TOTAL - 1);
    w_run       = r_state == RUN;
    // lcd_en only matters in IDLE and on the last pixel of a frame
    w_state_nxt = w_run ? ((w_h_end && w_v_end && !bus.lcd_en) ? IDLE : RUN) : (bus.lcd_en ? RUN : IDLE);
    w_h_nxt     = (!w_run || w_h_end) ? '0 : r_h + 1'b1;
    w_v_nxt     = !w_run ? '0 : !w_h_end ? r_v : w_v_end ? '0 : r_v + 1'b1;
    w_hs        = w_run && int'(r_h) < H_SYNC;
    w_vs        = w_run && int'(r_v) < V_SYNC;
    w_act       = w_run && int'(r_h) >= H_A0 && int'(r_h) < H_A1 && int'(r_v) >= V_A0 && int'(r_v) < V_A1;
    w_fs        = w_run && r_h == '0 && r_v == '0;
    // r_req_d1 is the stage-2 copy of DE; no read behind it means the pixel goes out blank
    w_uf        = r_req_d1 && !r_rd_en_d1;
  end
  always_ff @(posedge lcd_clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_h        <= '0;
      r_v        <= '0;
      r_req      <= 1'b0;
      r_req_d1   <= 1'b0;
      r_rd_en_d1 <= 1'b0;
      r_rgb      <= '0;
      r_uf       <= 1'b0;
      r_uf_cnt   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_h        <= w_h_nxt;
      r_v        <= w_v_nxt;
      r_req      <= w_act;
      r_req_d1   <= r_req;
      r_rd_en_d1 <= bus.fifo_rd_en && r_req;
      r_rgb      <= r_rd_en_d1 ? bus.fifo_rd_data : '0;
      r_uf       <= w_uf;
      r_uf_cnt   <= (w_uf && r_uf_cnt != 16'hFFFF) ? r_uf_cnt + 16'd1 : r_uf_cnt;
    end
  end
  lcd_delay_line #(.DEPTH(PIPE_DEPTH), .WIDTH(4)) u_ctl_dly (
    .clk   (lcd_clk),
    .rst_n (rst_n),
    .i_d   ({w_act, w_hs, w_vs, w_fs}),
    .o_q   (w_ctl)
  );
  assign bus.lcd_data_requst = r_req;
  assign bus.lcd_de          = w_ctl[3];
  assign bus.lcd_hs          = w_ctl[2] ? HS_POL : ~HS_POL;
  assign bus.lcd_vs          = w_ctl[1] ? VS_POL : ~VS_POL;
  assign bus.frame_start     = w_ctl[0];
  assign bus.lcd_rgb         = r_rgb;
  assign bus.lcd_underflow   = r_uf;
  assign bus.underflow_cnt   = r_uf_cnt;
endmodule

// File: tb/tb_lcd_timing_gen.sv
// tb_lcd_timing_gen: randomized self-checking bench against a frame-position reference model
module tb_lcd_timing_gen;
  localparam int HS = 2, HB = 3, HD = 8, HF = 2, VS = 1, VB = 1, VD = 4, VF = 1;
  localparam int HT = HS + HB + HD + HF, VT = VS + VB + VD + VF, PT = HT * VT;
  localparam int BHS = 1, BHB = 0, BHD = 254, BHF = 1, BVS = 1, BVB = 0, BVD = 254, BVF = 1;
  localparam int BHT = BHS + BHB + BHD + BHF, BPT = BHT * (BVS + BVB + BVD + BVF);
  typedef struct packed {logic act, hs, vs, fs, gr; logic [15:0] d;} rec_t;
  logic clk = 1'b0, rst_n = 1'b0, rst2_n = 1'b0;
  always #5 clk = ~clk;
  lcd_timing_gen_if #(.DATA_W(16)) bus ();
  lcd_timing_gen_if #(.DATA_W(16)) bus2 ();
  lcd_timing_gen #(.DATA_W(16), .H_SYNC(HS), .H_BACK(HB), .H_DISP(HD), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_DISP(VD), .V_FRONT(VF), .HS_POL(1'b0), .VS_POL(1'b0))
    dut (.lcd_clk(clk), .rst_n(rst_n), .bus(bus));
  lcd_timing_gen #(.DATA_W(16), .H_SYNC(BHS), .H_BACK(BHB), .H_DISP(BHD), .H_FRONT(BHF),
    .V_SYNC(BVS), .V_BACK(BVB), .V_DISP(BVD), .V_FRONT(BVF), .HS_POL(1'b0), .VS_POL(1'b0))
    dut2 (.lcd_clk(clk), .rst_n(rst2_n), .bus(bus2));
  int n_chk = 0, n_pass = 0, cyc = 0;
  bit drop = 0;
  logic [15:0] seq = 16'h0100;
  rec_t h1 [3] = '{default: '0};
  bit m_run = 0;
  int m_p = 0, m_cnt = 0;
  bit h2 [3] = '{default: 1'b0};
  bit m2_run = 0;
  int m2_p = 0, m2_cnt = 0, n2_total = 0;
  bit w_on = 0, seq_on = 0, have_last = 0;
  int w_de, w_hsl, w_vsl, w_fs, w_req, w_uf, w_ufde, last_fs;
  logic [15:0] last_rgb;
  task automatic chk1(input string nm, input logic got, input logic exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0b expected %0b at cycle %0d", nm, got, exp, cyc);
    else n_pass++;
  endtask
  task automatic chk16(input string nm, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, got, exp, cyc);
    else n_pass++;
  endtask
  task automatic chki(input string nm, input int got, input int exp);
    n_chk++;
    if (got != exp) $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, got, exp, cyc);
    else n_pass++;
  endtask
  // what the panel timing rules say about frame position p
  function automatic rec_t dec(bit run, int p, int ht, int hs, int hb, int hd, int vs, int vb, int vd);
    int h, v;
    h = p % ht;
    v = p / ht;
    dec = '0;
    if (run) begin
      dec.act = h >= hs + hb && h < hs + hb + hd && v >= vs + vb && v < vs + vb + vd;
      dec.hs  = h < hs;
      dec.vs  = v < vs;
      dec.fs  = p == 0;
    end
  endfunction
  task automatic clear_win();
    w_de = 0; w_hsl = 0; w_vsl = 0; w_fs = 0; w_req = 0; w_uf = 0; w_ufde = 0;
    last_fs = -1; have_last = 0;
  endtask
  task automatic tick();
    rec_t cur;
    bit a2, e_uf, e_uf2;
    cur = dec(m_run, m_p, HT, HS, HB, HD, VS, VB, VD);
    bus.fifo_rd_en = h1[0].act ? !drop : ($urandom_range(0, 3) == 0);
    cur.gr = bus.fifo_rd_en && h1[0].act;
    bus.fifo_rd_data = h1[0].gr ? seq : 16'($urandom);
    if (h1[0].gr) seq++;
    cur.d = bus.fifo_rd_data;
    a2 = dec(m2_run, m2_p, BHT, BHS, BHB, BHD, BVS, BVB, BVD).act;
    if (!rst_n) begin
      m_run = 0; m_p = 0; m_cnt = 0; h1 = '{default: '0};
    end else begin
      h1[2] = h1[1]; h1[1] = h1[0]; h1[0] = cur;
      if (m_run) begin
        if (m_p == PT - 1 && !bus.lcd_en) begin m_run = 0; m_p = 0; end
        else m_p = (m_p + 1) % PT;
      end else if (bus.lcd_en) begin m_run = 1; m_p = 0; end
    end
    if (!rst2_n) begin
      m2_run = 0; m2_p = 0; m2_cnt = 0; h2 = '{default: 1'b0};
    end else begin
      h2[2] = h2[1]; h2[1] = h2[0]; h2[0] = a2;
      if (m2_run) m2_p = (m2_p + 1) % BPT;
      else begin m2_run = 1; m2_p = 0; end
    end
    @(posedge clk);
    #1;
    cyc++;
    e_uf = h1[2].act && !h1[1].gr;
    if (e_uf && m_cnt < 65535) m_cnt++;
    chk1("req", bus.lcd_data_requst, h1[0].act);
    chk1("de", bus.lcd_de, h1[2].act);
    chk1("hs", bus.lcd_hs, !h1[2].hs);
    chk1("vs", bus.lcd_vs, !h1[2].vs);
    chk1("frame_start", bus.frame_start, h1[2].fs);
    chk1("underflow", bus.lcd_underflow, e_uf);
    chk16("rgb", bus.lcd_rgb, h1[1].gr ? h1[0].d : 16'd0);
    chk16("underflow_cnt", bus.underflow_cnt, 16'(m_cnt));
    e_uf2 = h2[2];
    if (e_uf2) n2_total++;
    if (e_uf2 && m2_cnt < 65535) m2_cnt++;
    chk1("sat_de", bus2.lcd_de, h2[2]);
    chk1("sat_underflow", bus2.lcd_underflow, e_uf2);
    chk16("sat_cnt_track", bus2.underflow_cnt, 16'(m2_cnt));
    if (w_on) begin
      w_de += int'(bus.lcd_de);
      w_hsl += int'(!bus.lcd_hs);
      w_vsl += int'(!bus.lcd_vs);
      w_fs += int'(bus.frame_start);
      w_req += int'(bus.lcd_data_requst);
      w_uf += int'(bus.lcd_underflow);
      w_ufde += int'(bus.lcd_underflow && bus.lcd_de);
      if (seq_on && bus.lcd_de) begin
        if (have_last) chk16("rgb_consecutive", bus.lcd_rgb, last_rgb + 16'd1);
        last_rgb = bus.lcd_rgb;
        have_last = 1;
      end
      if (seq_on && bus.frame_start) begin
        if (last_fs >= 0) chki("frame_period", cyc - last_fs, 105);
        last_fs = cyc;
      end
    end
  endtask
  initial begin
    int left, n, quiet, guard;
    bus.lcd_en = 1'b1; bus.fifo_rd_en = 1'b0; bus.fifo_rd_data = '0;
    bus2.lcd_en = 1'b1; bus2.fifo_rd_en = 1'b0; bus2.fifo_rd_data = '0;
    clear_win();
    repeat (5) tick();
    chk1("reset_hs", bus.lcd_hs, 1'b1);
    chk1("reset_vs", bus.lcd_vs, 1'b1);
    chk1("reset_de", bus.lcd_de, 1'b0);
    chk1("reset_req", bus.lcd_data_requst, 1'b0);
    chk16("reset_ucnt", bus.underflow_cnt, 16'd0);
    rst_n = 1'b1; rst2_n = 1'b1;
    repeat (120) tick();
    clear_win(); w_on = 1; seq_on = 1;
    repeat (3 * PT) tick();
    w_on = 0; seq_on = 0;
    chki("steady_de", w_de, 96);
    chki("steady_req", w_req, 96);
    chki("steady_hs_low", w_hsl, 42);
    chki("steady_vs_low", w_vsl, 45);
    chki("steady_fs", w_fs, 3);
    chki("steady_uf", w_uf, 0);
    clear_win(); w_on = 1; left = 3;
    repeat (PT) begin
      drop = h1[0].act && left > 0;
      if (drop) left--;
      tick();
    end
    drop = 0; w_on = 0;
    chki("uf_pulses", w_uf, 3);
    chki("uf_with_de", w_ufde, 3);
    chk16("uf_cnt3", bus.underflow_cnt, 16'd3);
    repeat (2 * PT) begin
      drop = h1[0].act && $urandom_range(0, 4) == 0;
      tick();
    end
    drop = 0;
    guard = 0;
    while (m_p != 50 && guard < 2 * PT) begin tick(); guard++; end
    chki("reach_p50", m_p, 50);
    bus.lcd_en = 1'b0;
    n = 0;
    while (m_run && n < 2 * PT) begin tick(); n++; end
    chki("frame_completes", n, 55);
    quiet = 0;
    repeat (40) begin
      tick();
      quiet += int'(bus.lcd_data_requst) + int'(bus.lcd_de) + int'(!bus.lcd_hs) + int'(!bus.lcd_vs) + int'(bus.frame_start);
    end
    chki("idle_quiet", quiet, 0);
    bus.lcd_en = 1'b1;
    repeat (3) tick();
    chk1("restart_fs_early", bus.frame_start, 1'b0);
    tick();
    chk1("restart_fs", bus.frame_start, 1'b1);
    chk1("restart_vs", bus.lcd_vs, 1'b0);
    chk1("restart_hs", bus.lcd_hs, 1'b0);
    guard = 0;
    while (!bus.lcd_de && guard < 2 * PT) begin tick(); guard++; end
    chk1("de_seen", bus.lcd_de, 1'b1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk1("midrst_de", bus.lcd_de, 1'b0);
    chk16("midrst_rgb", bus.lcd_rgb, 16'd0);
    chk1("midrst_req", bus.lcd_data_requst, 1'b0);
    chk16("midrst_ucnt", bus.underflow_cnt, 16'd0);
    chk1("midrst_hs", bus.lcd_hs, 1'b1);
    repeat (8 * PT) begin
      if ($urandom_range(0, 59) == 0) bus.lcd_en = !bus.lcd_en;
      rst_n = $urandom_range(0, 399) != 0;
      drop = h1[0].act && $urandom_range(0, 5) == 0;
      tick();
    end
    rst_n = 1'b1; drop = 0; bus.lcd_en = 1'b1;
    while (n2_total < 65600 && cyc < 80000) tick();
    chki("sat_budget", int'(n2_total >= 65600), 1);
    chk16("sat_cnt_final", bus2.underflow_cnt, 16'hFFFF);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
